btn_keypad: RTL and testbench

BTN_KEYPAD -- requirements
Module: btn_keypad

---
 rtl/btn_keypad.sv | 122 ++++++++++++
 tb/tb_btn_keypad.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/btn_keypad.sv
// Five-button keypad to Hack keyboard codes with hold-to-repeat; all outputs registered,
// one-cycle press latency, no backpressure (key_event is a single-cycle strobe).
module btn_keypad #(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  btn,
    output logic [15:0] kbd_code,
    output logic        key_event,
    output logic        key_held
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [31:0] DELAY_TC  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_TC = 32'(REPEAT_PERIOD - 1);

    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [15:0] code_nxt;
    logic        event_nxt;
    logic        held_nxt;
    logic [2:0]  press_idx;
    logic [31:0] term_cnt;

    function automatic logic [2:0] lowest_set(input logic [4:0] b);
        logic [2:0] r;
        casez (b)
            5'b????1: r = 3'd0;
            5'b???10: r = 3'd1;
            5'b??100: r = 3'd2;
            5'b?1000: r = 3'd3;
            5'b10000: r = 3'd4;
            default:  r = 3'd0;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] code_of(input logic [2:0] k);
        logic [15:0] c;
        case (k)
            3'd0:    c = 16'd128;
            3'd1:    c = 16'd131;
            3'd2:    c = 16'd130;
            3'd3:    c = 16'd132;
            3'd4:    c = 16'd133;
            default: c = 16'd0;
        endcase
        return c;
    endfunction

    assign press_idx = lowest_set(btn);
    assign term_cnt  = (state == HELD) ? DELAY_TC : PERIOD_TC;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        code_nxt  = kbd_code;
        event_nxt = 1'b0;
        held_nxt  = key_held;
        case (state)
            IDLE: begin
                if (btn != 5'd0) begin
                    state_nxt = HELD;
                    idx_nxt   = press_idx;
                    cnt_nxt   = 32'd0;
                    code_nxt  = code_of(press_idx);
                    event_nxt = 1'b1;
                    held_nxt  = 1'b1;
                end
            end
            HELD, REPEAT: begin
                // Release wins over a terminal count landing on the same edge.
                if (!btn[idx]) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 32'd0;
                    code_nxt  = 16'd0;
                    held_nxt  = 1'b0;
                end else if (cnt == term_cnt) begin
                    state_nxt = REPEAT;
                    cnt_nxt   = 32'd0;
                    event_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 32'd0;
                code_nxt  = 16'd0;
                held_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= 32'd0;
            kbd_code  <= 16'd0;
            key_event <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            kbd_code  <= code_nxt;
            key_event <= event_nxt;
            key_held  <= held_nxt;
        end
    end

endmodule

// File: tb/tb_btn_keypad.sv
// Bench for btn_keypad: directed scenarios plus random button traffic against a press-age model.
module tb_btn_keypad;

    localparam int DLY = 8;
    localparam int PER = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  btn;
    logic [15:0] kbd_code;
    logic        key_event;
    logic        key_held;

    int n_chk = 0;
    int n_err = 0;

    bit          m_active;
    int          m_key;
    int          m_age;
    bit          m_evt;
    logic [15:0] m_code;
    logic        prev_evt;

    int codes [5] = '{128, 131, 130, 132, 133};

    btn_keypad #(.REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (btn),
        .kbd_code  (kbd_code),
        .key_event (key_event),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: key age in edges since the press; events at age 0, DLY, DLY+k*PER.
    task automatic model_edge(input logic [4:0] b);
        m_evt = 1'b0;
        if (!m_active) begin
            if (b != 5'd0) begin
                m_active = 1'b1;
                m_key = 0;
                while (!b[m_key]) m_key++;
                m_age = 0;
                m_evt = 1'b1;
            end
        end else if (!b[m_key]) begin
            m_active = 1'b0;
        end else begin
            m_age++;
            if (m_age == DLY) m_evt = 1'b1;
            else if (m_age > DLY && ((m_age - DLY) % PER) == 0) m_evt = 1'b1;
        end
        m_code = m_active ? 16'(codes[m_key]) : 16'd0;
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_key    = 0;
        m_age    = 0;
        m_evt    = 1'b0;
        m_code   = 16'd0;
        prev_evt = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(btn);
        #1;
        chk("kbd", 32'(kbd_code), 32'(m_code));
        chk("evt", 32'(key_event), 32'(m_evt));
        chk("held", 32'(key_held), 32'(m_active));
        chk("no_dbl_evt", 32'(key_event & prev_evt), 32'd0);
        prev_evt = key_event;
    endtask

    // Called 1 time unit after a rising edge; reset pulse sits entirely between edges.
    task automatic reset_between_edges();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_kbd", 32'(kbd_code), 32'd0);
        chk("rst_evt", 32'(key_event), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        btn     = 5'd0;
        model_reset();
        #2;
        chk("por_kbd", 32'(kbd_code), 32'd0);
        chk("por_evt", 32'(key_event), 32'd0);
        chk("por_held", 32'(key_held), 32'd0);
        #20;
        reset_n = 1'b1;
        step();
        step();

        // Short U press
        btn = 5'b00010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("u_kbd", 32'(kbd_code), 32'd131);
            chk("u_evt", 32'(key_event), 32'(i == 0));
        end
        btn = 5'b00000;
        step();
        chk("u_rel_kbd", 32'(kbd_code), 32'd0);
        step();

        // Long R hold with auto-repeat
        btn = 5'b01000;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("r_evt", 32'(key_event), 32'(i == 1 || i == 9 || i == 13 || i == 17));
            chk("r_kbd", 32'(kbd_code), 32'd132);
        end
        btn = 5'b00000;
        step();
        step();

        // L and D together; L wins, D takes over after release
        btn = 5'b10100;
        step();
        chk("ld_kbd", 32'(kbd_code), 32'd130);
        chk("ld_evt", 32'(key_event), 32'd1);
        btn = 5'b10000;
        step();
        chk("ld_idle_kbd", 32'(kbd_code), 32'd0);
        chk("ld_idle_held", 32'(key_held), 32'd0);
        step();
        chk("d_kbd", 32'(kbd_code), 32'd133);
        chk("d_evt", 32'(key_event), 32'd1);
        btn = 5'b00000;
        step();
        step();

        // U held, R toggled underneath
        btn = 5'b00010;
        step();
        for (int i = 0; i < 4; i++) begin
            btn = (i % 2 == 0) ? 5'b01010 : 5'b00010;
            step();
            chk("tog_kbd", 32'(kbd_code), 32'd131);
            chk("tog_evt", 32'(key_event), 32'd0);
        end
        btn = 5'b00000;
        step();
        step();

        // Release on the repeat terminal count
        btn = 5'b00001;
        step();
        for (int i = 0; i < DLY + PER - 1; i++) step();
        btn = 5'b00000;
        step();
        chk("tc_rel_evt", 32'(key_event), 32'd0);
        chk("tc_rel_kbd", 32'(kbd_code), 32'd0);
        step();

        // Reset mid-REPEAT with C still held
        btn = 5'b00001;
        step();
        for (int i = 0; i < DLY + 2; i++) step();
        reset_between_edges();
        step();
        chk("post_rst_kbd", 32'(kbd_code), 32'd128);
        chk("post_rst_evt", 32'(key_event), 32'd1);
        btn = 5'b00000;
        step();
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) btn = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) reset_between_edges();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
